// File: rtl/nco_pkg.sv
// Shared constants and helpers for the NCO phase generator and its sine/cosine ROM.
// Holds the dither LFSR definition and the width-legality check.
package nco_pkg;

   localparam int          LFSR_WIDTH = 32;
   // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED  = 32'h0000_0001;

   function automatic logic [31:0] lfsr_next(input logic [31:0] state);
      logic [31:0] next_s;
      next_s = {1'b0, state[31:1]};
      if (state[0]) begin
         next_s = next_s ^ LFSR_TAPS;
      end else begin
         next_s = next_s;
      end
      return next_s;
   endfunction

   function automatic logic nco_params_ok(input int acc_width, input int width,
                                          input int dither_width);
      return (width >= 1) && (width <= acc_width) && (dither_width >= 0) &&
             (dither_width <= acc_width - width) && (dither_width <= LFSR_WIDTH);
   endfunction

endpackage

// File: rtl/nco_lfsr.sv
// Enable-gated 32-bit Galois LFSR supplying the low dither bits of the phase sum.
module nco_lfsr
   import nco_pkg::*;
#(
   parameter int DITHER_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clkena,
   output logic [DITHER_WIDTH-1:0] dither
);

   logic [LFSR_WIDTH-1:0] state_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= LFSR_SEED;
      end else if (clkena) begin
         state_r <= lfsr_next(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign dither = state_r[DITHER_WIDTH-1:0];

endmodule

// File: rtl/nco_phase_acc.sv
// Phase accumulator feeding rom_sin_cos: acc -> (offset + dither) sum -> truncated arg,
// all stages gated by the ROM's clkena; wrap travels alongside the sample it belongs to.
module nco_phase_acc
   import nco_pkg::*;
#(
   parameter int ACC_WIDTH    = 32,
   parameter int WIDTH        = 16,
   parameter int DITHER_WIDTH = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clkena,
   input  logic                 freq_wr,
   input  logic [ACC_WIDTH-1:0] freq,
   input  logic                 phase_wr,
   input  logic [ACC_WIDTH-1:0] phase,
   input  logic                 sync,
   output logic [WIDTH-1:0]     arg,
   output logic                 wrap
);

   if (!nco_params_ok(ACC_WIDTH, WIDTH, DITHER_WIDTH)) begin : g_param_err
      $error("nco_phase_acc: need WIDTH <= ACC_WIDTH and DITHER_WIDTH <= ACC_WIDTH-WIDTH");
   end

   logic [ACC_WIDTH-1:0] freq_r;
   logic [ACC_WIDTH-1:0] phase_r;
   logic [ACC_WIDTH-1:0] acc_r;
   logic                 carry_r;
   logic                 sync_pend_r;
   logic [WIDTH-1:0]     sum_r;
   logic                 carry_d_r;
   logic [WIDTH-1:0]     arg_r;
   logic                 wrap_r;

   logic [ACC_WIDTH-1:0] dither_s;
   logic [ACC_WIDTH:0]   acc_next_s;
   logic [ACC_WIDTH-1:0] tap_s;
   logic [WIDTH-1:0]     tap_top_s;

   if (DITHER_WIDTH > 0) begin : g_dither
      logic [DITHER_WIDTH-1:0] lfsr_bits_s;

      nco_lfsr #(
         .DITHER_WIDTH(DITHER_WIDTH)
      ) u_lfsr (
         .clk    (clk),
         .reset  (reset),
         .clkena (clkena),
         .dither (lfsr_bits_s)
      );

      assign dither_s = ACC_WIDTH'(lfsr_bits_s);
   end else begin : g_no_dither
      assign dither_s = {ACC_WIDTH{1'b0}};
   end

   assign acc_next_s = {1'b0, acc_r} + {1'b0, freq_r};
   assign tap_s      = acc_r + phase_r + dither_s;
   // only the top WIDTH bits of the sum ever reach the ROM
   assign tap_top_s  = WIDTH'(tap_s >> (ACC_WIDTH - WIDTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         freq_r  <= {ACC_WIDTH{1'b0}};
         phase_r <= {ACC_WIDTH{1'b0}};
      end else begin
         if (freq_wr) begin
            freq_r <= freq;
         end else begin
            freq_r <= freq_r;
         end
         if (phase_wr) begin
            phase_r <= phase;
         end else begin
            phase_r <= phase_r;
         end
      end
   end

   // A sync seen while disabled is parked in sync_pend_r until the next enabled edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r       <= {ACC_WIDTH{1'b0}};
         carry_r     <= 1'b0;
         sync_pend_r <= 1'b0;
      end else if (clkena) begin
         if (sync || sync_pend_r) begin
            acc_r       <= {ACC_WIDTH{1'b0}};
            carry_r     <= 1'b0;
            sync_pend_r <= 1'b0;
         end else begin
            {carry_r, acc_r} <= acc_next_s;
            sync_pend_r      <= 1'b0;
         end
      end else begin
         if (sync) begin
            sync_pend_r <= 1'b1;
         end else begin
            sync_pend_r <= sync_pend_r;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_r     <= {WIDTH{1'b0}};
         carry_d_r <= 1'b0;
         arg_r     <= {WIDTH{1'b0}};
         wrap_r    <= 1'b0;
      end else if (clkena) begin
         sum_r     <= tap_top_s;
         carry_d_r <= carry_r;
         arg_r     <= sum_r;
         wrap_r    <= carry_d_r;
      end else begin
         sum_r     <= sum_r;
         carry_d_r <= carry_d_r;
         arg_r     <= arg_r;
         wrap_r    <= wrap_r;
      end
   end

   assign arg  = arg_r;
   assign wrap = wrap_r;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Self-checking bench: a plain-arithmetic phase model drives expectations for an
// undithered and a 4-bit dithered instance under directed and random stimulus.
module tb_nco_phase_acc;

   localparam longint unsigned MOD = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        reset, clkena, freq_wr, phase_wr, sync;
   logic [31:0] freq, phase;
   logic [15:0] arg0, arg1;
   logic        wrap0, wrap1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nco_phase_acc dut0 (
      .clk(clk), .reset(reset), .clkena(clkena), .freq_wr(freq_wr), .freq(freq),
      .phase_wr(phase_wr), .phase(phase), .sync(sync), .arg(arg0), .wrap(wrap0)
   );

   nco_phase_acc #(.ACC_WIDTH(32), .WIDTH(16), .DITHER_WIDTH(4)) dut1 (
      .clk(clk), .reset(reset), .clkena(clkena), .freq_wr(freq_wr), .freq(freq),
      .phase_wr(phase_wr), .phase(phase), .sync(sync), .arg(arg1), .wrap(wrap1)
   );

   // Reference model: mathematical phase with explicit overflow detection.
   longint unsigned m_acc, m_freq, m_phase;
   bit              m_ovf, m_pend;
   logic [31:0]     m_lfsr;
   logic [15:0]     m_stage_arg [2];
   bit              m_stage_wrap[2];
   logic [15:0]     exp_arg [2];
   bit              exp_wrap[2];

   function automatic logic [31:0] ref_lfsr_step(input logic [31:0] s);
      int          exps [4];
      logic [31:0] mask;
      logic [31:0] r;
      exps[0] = 32; exps[1] = 22; exps[2] = 2; exps[3] = 1;
      mask = 32'h0;
      for (int k = 0; k < 4; k++) mask[exps[k]-1] = 1'b1;
      r = s >> 1;
      if (s[0]) r = r ^ mask;
      return r;
   endfunction

   task automatic model_edge();
      longint unsigned nxt, t;
      if (reset) begin
         m_acc = 0; m_freq = 0; m_phase = 0; m_ovf = 0; m_pend = 0;
         m_lfsr = 32'h1;
         for (int i = 0; i < 2; i++) begin
            m_stage_arg[i] = 16'h0; m_stage_wrap[i] = 1'b0;
            exp_arg[i] = 16'h0;     exp_wrap[i] = 1'b0;
         end
      end else begin
         if (clkena) begin
            for (int i = 0; i < 2; i++) begin
               t = (m_acc + m_phase + ((i == 1) ? longint'(m_lfsr[3:0]) : 64'd0)) % MOD;
               exp_arg[i]      = m_stage_arg[i];
               exp_wrap[i]     = m_stage_wrap[i];
               m_stage_arg[i]  = 16'(t >> 16);
               m_stage_wrap[i] = m_ovf;
            end
            if (sync || m_pend) begin
               m_acc = 0; m_ovf = 0; m_pend = 0;
            end else begin
               nxt   = m_acc + m_freq;
               m_ovf = (nxt >= MOD);
               m_acc = nxt % MOD;
            end
            m_lfsr = ref_lfsr_step(m_lfsr);
         end else if (sync) begin
            m_pend = 1'b1;
         end
         if (freq_wr)  m_freq  = longint'(freq);
         if (phase_wr) m_phase = longint'(phase);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; clkena = 1'b0; freq_wr = 1'b0; phase_wr = 1'b0; sync = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic load_freq_disabled(input logic [31:0] f);
      clkena = 1'b0; freq_wr = 1'b1; freq = f;
      tick();
      freq_wr = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1; clkena = 1'b1; sync = 1'b1;
      freq_wr = 1'b1; freq = $urandom; phase_wr = 1'b1; phase = $urandom;
      tick();
      tick();
      idle_inputs();
      checks++; if (arg0 !== 16'h0)  begin errors++; $display("FAIL reset arg0: got %h expected 0000", arg0); end
      checks++; if (wrap0 !== 1'b0)  begin errors++; $display("FAIL reset wrap0: got %b expected 0", wrap0); end
      checks++; if (arg1 !== 16'h0)  begin errors++; $display("FAIL reset arg1: got %h expected 0000", arg1); end
      checks++; if (wrap1 !== 1'b0)  begin errors++; $display("FAIL reset wrap1: got %b expected 0", wrap1); end
      // freq written during reset must be discarded: an enabled run stays at zero
      clkena = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      clkena = 1'b0;
      checks++; if (arg0 !== 16'h0)  begin errors++; $display("FAIL reset_prio arg0: got %h expected 0000", arg0); end
   endtask

   task automatic test_ramp();
      logic [15:0] want;
      do_reset();
      load_freq_disabled(32'h0001_0000);
      clkena = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         tick();
         want = (n <= 2) ? 16'h0 : 16'(n - 2);
         checks++; if (arg0 !== want) begin errors++; $display("FAIL ramp arg e%0d: got %h expected %h", n, arg0, want); end
         checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL ramp wrap e%0d: got %b expected 0", n, wrap0); end
      end
      clkena = 1'b0;
   endtask

   task automatic test_half_cycle();
      logic [15:0] want_a;
      bit          want_w;
      do_reset();
      load_freq_disabled(32'h8000_0000);
      clkena = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         tick();
         want_a = (n >= 3 && (n % 2) == 1) ? 16'h8000 : 16'h0000;
         want_w = (n >= 4 && (n % 2) == 0);
         checks++; if (arg0 !== want_a) begin errors++; $display("FAIL half arg e%0d: got %h expected %h", n, arg0, want_a); end
         checks++; if (wrap0 !== want_w) begin errors++; $display("FAIL half wrap e%0d: got %b expected %b", n, wrap0, want_w); end
      end
      clkena = 1'b0;
   endtask

   task automatic test_offset();
      logic [15:0] want;
      do_reset();
      load_freq_disabled(32'h0001_0000);
      clkena = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         if (n == 7) begin phase_wr = 1'b1; phase = 32'h4000_0000; end
         tick();
         phase_wr = 1'b0;
         want = (n <= 2) ? 16'h0 : ((n >= 9) ? 16'(n - 2) + 16'h4000 : 16'(n - 2));
         checks++; if (arg0 !== want) begin errors++; $display("FAIL offset arg e%0d: got %h expected %h", n, arg0, want); end
         checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL offset wrap e%0d: got %b expected 0", n, wrap0); end
      end
      clkena = 1'b0;
   endtask

   task automatic test_sync_disabled();
      logic [15:0] want [4];
      want[0] = 16'd5; want[1] = 16'd6; want[2] = 16'd0; want[3] = 16'd1;
      do_reset();
      load_freq_disabled(32'h0001_0000);
      clkena = 1'b1;
      for (int n = 0; n < 6; n++) tick();
      clkena = 1'b0; sync = 1'b1;
      tick();
      sync = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++; if (arg0 !== 16'd4) begin errors++; $display("FAIL sync_frozen arg: got %h expected 0004", arg0); end
      end
      clkena = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++; if (arg0 !== want[n]) begin errors++; $display("FAIL sync_pend arg step%0d: got %h expected %h", n, arg0, want[n]); end
      end
      clkena = 1'b0;
   endtask

   task automatic test_sync_freq();
      do_reset();
      load_freq_disabled(32'h0001_0000);
      clkena = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      sync = 1'b1; freq_wr = 1'b1; freq = 32'h0002_0000;
      tick();
      sync = 1'b0; freq_wr = 1'b0;
      tick();
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++; if (arg0 !== 16'(2 * n)) begin errors++; $display("FAIL sync_freq arg step%0d: got %h expected %h", n, arg0, 16'(2 * n)); end
         checks++; if (arg0 !== exp_arg[0]) begin errors++; $display("FAIL sync_freq model step%0d: got %h expected %h", n, arg0, exp_arg[0]); end
      end
      clkena = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         reset    = ($urandom_range(0, 59) == 0);
         clkena   = ($urandom_range(0, 3) != 0);
         sync     = ($urandom_range(0, 15) == 0);
         freq_wr  = ($urandom_range(0, 7) == 0);
         phase_wr = ($urandom_range(0, 7) == 0);
         freq     = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> 4);
         phase    = $urandom;
         tick();
         checks++; if (arg0 !== exp_arg[0])   begin errors++; $display("FAIL random arg0 #%0d: got %h expected %h", n, arg0, exp_arg[0]); end
         checks++; if (wrap0 !== exp_wrap[0]) begin errors++; $display("FAIL random wrap0 #%0d: got %b expected %b", n, wrap0, exp_wrap[0]); end
         checks++; if (arg1 !== exp_arg[1])   begin errors++; $display("FAIL random arg1 #%0d: got %h expected %h", n, arg1, exp_arg[1]); end
         checks++; if (wrap1 !== exp_wrap[1]) begin errors++; $display("FAIL random wrap1 #%0d: got %b expected %b", n, wrap1, exp_wrap[1]); end
      end
      idle_inputs();
   endtask

   task automatic test_dither();
      int dut_ones, ref_ones, diff;
      dut_ones = 0; ref_ones = 0;
      do_reset();
      freq_wr = 1'b1; freq = 32'h0; phase_wr = 1'b1; phase = 32'h0000_FFF8;
      tick();
      freq_wr = 1'b0; phase_wr = 1'b0;
      clkena = 1'b1;
      tick();
      tick();
      for (int n = 0; n < 10000; n++) begin
         tick();
         if (arg1 == 16'h0001) dut_ones++;
         if (exp_arg[1] == 16'h0001) ref_ones++;
         checks++; if (arg1 !== exp_arg[1]) begin errors++; $display("FAIL dither arg #%0d: got %h expected %h", n, arg1, exp_arg[1]); end
         checks++; if (arg0 !== 16'h0000)   begin errors++; $display("FAIL nodither arg #%0d: got %h expected 0000", n, arg0); end
      end
      diff = dut_ones - ref_ones;
      if (diff < 0) diff = -diff;
      checks++; if (diff > 100) begin errors++; $display("FAIL dither mean: got %0d ones expected %0d within 100", dut_ones, ref_ones); end
      clkena = 1'b0;
   endtask

   initial begin
      idle_inputs();
      freq = 32'h0; phase = 32'h0;
      test_reset();
      test_ramp();
      test_half_cycle();
      test_offset();
      test_sync_disabled();
      test_sync_freq();
      test_random();
      test_dither();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
